// File: rtl/ahb_master_arbiter.sv
// AHB-Lite master front end for the RISC-V core: arbitrates instruction fetch
// against load/store, runs one transfer at a time on the shared master port,
// and returns read data with a per-requester ack or error pulse.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transfer; arbitrate and latch the winner's attributes
// ADDR  | address phase on the bus (htrans=NONSEQ), waits on hready
// DATA  | data phase, waits on hready, watches hresp
// ERR   | second cycle of the ERROR response, waits on hready
// RESP  | one-cycle ack/err pulse to the owner, no arbitration
module ahb_master_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   output logic              f_err,
   input  logic              d_req,
   input  logic              d_write,
   input  logic [2:0]        d_fn3,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic              d_err,
   output logic              d_misalign,
   output logic [DATA_W-1:0] rdata,
   output logic              is_signed,
   output logic              muxsel,
   output logic              busy,
   output logic [1:0]        htrans,
   output logic [ADDR_W-1:0] haddr,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [3:0]        hprot,
   output logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] hrdata,
   input  logic              hready,
   input  logic              hresp
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_ERR,
      S_RESP
   } state_t;

   localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

   state_t            state;
   logic [3:0]        run_cnt;
   logic [DATA_W-1:0] wdata_q;

   logic              grant_f;
   logic              grant_d;
   logic [2:0]        d_size;
   logic              d_mis;

   // Arbitration winner, data transfer size and alignment, from live requests
   always_comb begin
      grant_f = f_req && (!d_req || (run_cnt == RUN_MAX));
      grant_d = d_req && !grant_f;
      case (d_fn3)
         3'b000, 3'b100: d_size = 3'b000;
         3'b001, 3'b101: d_size = 3'b001;
         default:        d_size = 3'b010;
      endcase
      d_mis = ((d_size == 3'b001) && d_addr[0]) ||
              ((d_size == 3'b010) && (d_addr[1:0] != 2'b00));
   end

   // Transfer sequencer; every bus and core-side output is registered here
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state      <= S_IDLE;
         run_cnt    <= '0;
         wdata_q    <= '0;
         f_ack      <= 1'b0;
         f_err      <= 1'b0;
         d_ack      <= 1'b0;
         d_err      <= 1'b0;
         d_misalign <= 1'b0;
         rdata      <= '0;
         is_signed  <= 1'b0;
         muxsel     <= 1'b0;
         busy       <= 1'b0;
         htrans     <= 2'b00;
         haddr      <= '0;
         hwrite     <= 1'b0;
         hsize      <= 3'b000;
         hprot      <= 4'b0000;
         hwdata     <= '0;
      end else begin
         f_ack      <= 1'b0;
         f_err      <= 1'b0;
         d_ack      <= 1'b0;
         d_err      <= 1'b0;
         d_misalign <= 1'b0;
         // the data run only limits starvation of a fetch that is waiting
         if (!f_req) run_cnt <= '0;
         case (state)
            S_IDLE: begin
               if (grant_f) begin
                  run_cnt   <= '0;
                  muxsel    <= 1'b1;
                  is_signed <= 1'b0;
                  busy      <= 1'b1;
                  htrans    <= 2'b10;
                  haddr     <= f_addr;
                  hwrite    <= 1'b0;
                  hsize     <= 3'b010;
                  hprot     <= 4'b0000;
                  state     <= S_ADDR;
               end else if (grant_d) begin
                  if (f_req) run_cnt <= run_cnt + 4'd1;
                  muxsel    <= 1'b0;
                  is_signed <= (d_fn3 == 3'b000) || (d_fn3 == 3'b001) ||
                               (d_fn3 == 3'b010);
                  busy      <= 1'b1;
                  if (d_mis) begin
                     d_err      <= 1'b1;
                     d_misalign <= 1'b1;
                     state      <= S_RESP;
                  end else begin
                     htrans  <= 2'b10;
                     haddr   <= d_addr;
                     hwrite  <= d_write;
                     hsize   <= d_size;
                     hprot   <= 4'b0001;
                     wdata_q <= d_wdata;
                     state   <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               if (hready) begin
                  htrans <= 2'b00;
                  if (hwrite) hwdata <= wdata_q;
                  state <= S_DATA;
               end
            end
            S_DATA: begin
               if (hresp) begin
                  state <= S_ERR;
               end else if (hready) begin
                  if (!hwrite) rdata <= hrdata;
                  if (muxsel) f_ack <= 1'b1;
                  else        d_ack <= 1'b1;
                  state <= S_RESP;
               end
            end
            S_ERR: begin
               if (hready) begin
                  if (muxsel) f_err <= 1'b1;
                  else        d_err <= 1'b1;
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy   <= 1'b0;
               htrans <= 2'b00;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: a transaction-level model predicts
// the registered outputs every cycle, and each scenario also checks a few
// hand-computed literal values.
module tb_ahb_master_arbiter;

   localparam int MAX_RUN = 4;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        f_req, d_req, d_write;
   logic [31:0] f_addr, d_addr, d_wdata;
   logic [2:0]  d_fn3;
   logic        f_ack, f_err, d_ack, d_err, d_misalign;
   logic [31:0] rdata, haddr, hwdata;
   logic        is_signed, muxsel, busy, hwrite;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [3:0]  hprot;
   logic [31:0] rd_val = 32'h0;
   logic        hready = 1'b1, hresp = 1'b0;

   int checks = 0;
   int failures = 0;

   ahb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(MAX_RUN)) dut (
      .hclk(hclk), .hreset(hreset),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err),
      .d_req(d_req), .d_write(d_write), .d_fn3(d_fn3), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err), .d_misalign(d_misalign),
      .rdata(rdata), .is_signed(is_signed), .muxsel(muxsel), .busy(busy),
      .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
      .hprot(hprot), .hwdata(hwdata), .hrdata(rd_val), .hready(hready),
      .hresp(hresp)
   );

   always #5 hclk = ~hclk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scripted slave: per-cycle hready/hresp, popped just after each edge
   bit rdy_q[$];
   bit resp_q[$];
   always @(posedge hclk) begin
      #1;
      hready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      hresp  = (resp_q.size() > 0) ? resp_q.pop_front() : 1'b0;
   end

   // Transaction model: one tenure at a time, expressed as bus phase plus
   // the attributes of the owner captured at grant
   int          cyc = 0;
   int          phase = 0;      // 0 free, 1 address, 2 data, 3 error, 4 reply
   int          m_run = 0;
   bit          m_store;
   logic [31:0] m_wdata;
   string       m_order = "";
   logic [1:0]  e_htrans = 0;
   logic [31:0] e_haddr = 0, e_hwdata = 0, e_rdata = 0;
   logic        e_hwrite = 0, e_busy = 0, e_mux = 0, e_sgn = 0;
   logic [2:0]  e_hsize = 0;
   logic [3:0]  e_hprot = 0;
   logic        e_fack = 0, e_ferr = 0, e_dack = 0, e_derr = 0, e_mis = 0;

   always @(posedge hclk) begin
      int  bytes;
      bit  take_f;
      cyc++;
      if (hreset) begin
         phase = 0; m_run = 0;
         e_htrans = 0; e_haddr = 0; e_hwdata = 0; e_rdata = 0; e_hwrite = 0;
         e_busy = 0; e_mux = 0; e_sgn = 0; e_hsize = 0; e_hprot = 0;
         e_fack = 0; e_ferr = 0; e_dack = 0; e_derr = 0; e_mis = 0;
      end else begin
         e_fack = 0; e_ferr = 0; e_dack = 0; e_derr = 0; e_mis = 0;
         if (!f_req) m_run = 0;
         if (phase == 0 && (f_req || d_req)) begin
            take_f = f_req && (!d_req || m_run >= MAX_RUN);
            e_busy = 1;
            e_mux  = take_f;
            if (take_f) begin
               m_order = {m_order, "F"};
               m_run = 0;
               e_sgn = 0; m_store = 0;
               e_htrans = 2'b10; e_haddr = f_addr; e_hwrite = 0;
               e_hsize = 3'd2; e_hprot = 4'd0;
               phase = 1;
            end else begin
               m_order = {m_order, "D"};
               m_run = f_req ? m_run + 1 : 0;
               bytes = (d_fn3[1:0] == 2'd0) ? 1 : (d_fn3[1:0] == 2'd1) ? 2 : 4;
               e_sgn = (d_fn3 < 3'd3);
               if ((int'(d_addr[1:0]) % bytes) != 0) begin
                  e_derr = 1; e_mis = 1;
                  phase = 4;
               end else begin
                  m_store = d_write; m_wdata = d_wdata;
                  e_htrans = 2'b10; e_haddr = d_addr; e_hwrite = d_write;
                  e_hsize = (bytes == 1) ? 3'd0 : (bytes == 2) ? 3'd1 : 3'd2;
                  e_hprot = 4'd1;
                  phase = 1;
               end
            end
         end else if (phase == 1 && hready) begin
            e_htrans = 0;
            if (m_store) e_hwdata = m_wdata;
            phase = 2;
         end else if (phase == 2 && hresp) begin
            phase = 3;
         end else if (phase == 2 && hready) begin
            if (!m_store) e_rdata = rd_val;
            if (e_mux) e_fack = 1; else e_dack = 1;
            phase = 4;
         end else if (phase == 3 && hready) begin
            if (e_mux) e_ferr = 1; else e_derr = 1;
            phase = 4;
         end else if (phase == 4) begin
            e_busy = 0;
            phase = 0;
         end
      end
   end

   // Per-cycle comparison of the DUT against the model
   always @(negedge hclk) begin
      if (cyc > 0) begin
         chk("htrans", htrans, e_htrans);
         chk("f_ack", f_ack, e_fack);
         chk("f_err", f_err, e_ferr);
         chk("d_ack", d_ack, e_dack);
         chk("d_err", d_err, e_derr);
         chk("d_misalign", d_misalign, e_mis);
         chk("busy", busy, e_busy);
         chk("muxsel", muxsel, e_mux);
         chk("rdata", rdata, e_rdata);
         if (e_htrans == 2'b10) begin
            chk("haddr", haddr, e_haddr);
            chk("hwrite", hwrite, e_hwrite);
            chk("hsize", hsize, e_hsize);
            chk("hprot", hprot, e_hprot);
         end
         if ((phase == 2 || phase == 3) && m_store) chk("hwdata", hwdata, e_hwdata);
         if (e_busy && !e_mux) chk("is_signed", is_signed, e_sgn);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge hclk);
   endtask

   initial begin
      int    n_addr, n_ack, n_err, n_fack, n_tr;
      string dut_order;
      bit    done;

      hreset = 1; f_req = 1; f_addr = 32'hA000_0000;
      d_req = 0; d_write = 0; d_fn3 = 0; d_addr = 0; d_wdata = 0;
      rd_val = 32'hFEED_0001;
      idle(3);
      chk("rst_htrans", htrans, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_hsize", hsize, 0);

      // 1: fetch leaving reset, zero-wait slave
      hreset = 0;
      idle(1);
      chk("t1_htrans", htrans, 2'b10);
      chk("t1_haddr", haddr, 32'hA000_0000);
      chk("t1_hprot", hprot, 0);
      idle(2);
      chk("t1_fack", f_ack, 1);
      chk("t1_muxsel", muxsel, 1);
      chk("t1_rdata", rdata, 32'hFEED_0001);
      f_req = 0;
      idle(2);

      // 2: halfword store with two address-phase wait states
      rdy_q.push_back(0); rdy_q.push_back(0);
      d_req = 1; d_write = 1; d_fn3 = 3'b001; d_addr = 32'hB000_0002;
      d_wdata = 32'h1234_5678;
      n_addr = 0; n_ack = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge hclk);
         if (c == 1) chk("t2_hsize", hsize, 3'b001);
         if (c == 4) begin
            chk("t2_hwdata", hwdata, 32'h1234_5678);
            chk("t2_dphase", htrans, 0);
         end
         if (htrans == 2'b10 && haddr == 32'hB000_0002) n_addr++;
         if (d_ack) begin n_ack++; d_req = 0; end
      end
      chk("t2_addr_cycles", n_addr, 3);
      chk("t2_ack_count", n_ack, 1);
      d_req = 0; d_write = 0;

      // 3: both requesters held, fetch forced after MAX_RUN data grants
      rd_val = 32'h3333_3333;
      m_order = "";
      dut_order = "";
      f_req = 1; f_addr = 32'hA000_0100;
      d_req = 1; d_fn3 = 3'b010; d_addr = 32'hB000_0010;
      done = 0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge hclk);
         if (f_ack) dut_order = {dut_order, "F"};
         if (d_ack) dut_order = {dut_order, "D"};
         if (dut_order.len() >= 10) begin
            f_req = 0; d_req = 0; done = 1;
         end
      end
      checks++;
      if (dut_order != "DDDDFDDDDF") begin
         failures++;
         $display("FAIL t3_dut_order: got %s expected DDDDFDDDDF", dut_order);
      end
      checks++;
      if (m_order != "DDDDFDDDDF") begin
         failures++;
         $display("FAIL t3_model_order: got %s expected DDDDFDDDDF", m_order);
      end
      f_req = 0; d_req = 0;
      idle(2);

      // 4: misaligned word load, never reaches the bus
      d_req = 1; d_write = 0; d_fn3 = 3'b010; d_addr = 32'hB000_0001;
      n_tr = 0;
      @(negedge hclk);
      chk("t4_derr", d_err, 1);
      chk("t4_mis", d_misalign, 1);
      chk("t4_dack", d_ack, 0);
      if (htrans == 2'b10) n_tr++;
      d_req = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge hclk);
         if (htrans == 2'b10) n_tr++;
      end
      chk("t4_no_transfer", n_tr, 0);

      // 5: two-cycle error response on a fetch
      rd_val = 32'hBAD0_BAD0;
      rdy_q.push_back(1); rdy_q.push_back(0); rdy_q.push_back(1);
      resp_q.push_back(0); resp_q.push_back(1); resp_q.push_back(1);
      f_req = 1; f_addr = 32'hA000_0200;
      n_err = 0; n_fack = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge hclk);
         if (c == 4) chk("t5_ferr_cycle", f_err, 1);
         if (f_err) begin n_err++; f_req = 0; end
         if (f_ack) n_fack++;
      end
      chk("t5_ferr_count", n_err, 1);
      chk("t5_fack_count", n_fack, 0);
      chk("t5_rdata_kept", rdata, 32'h3333_3333);
      f_req = 0;
      idle(1);

      // 6: reset in the data phase, then a fresh access
      rdy_q.push_back(1); rdy_q.push_back(0);
      d_req = 1; d_write = 0; d_fn3 = 3'b100; d_addr = 32'hB000_0020;
      idle(2);
      hreset = 1;
      idle(1);
      chk("t6_htrans", htrans, 0);
      chk("t6_haddr", haddr, 0);
      chk("t6_hprot", hprot, 0);
      chk("t6_rdata", rdata, 0);
      chk("t6_busy", busy, 0);
      chk("t6_muxsel", muxsel, 0);
      hreset = 0; d_req = 0;
      n_ack = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge hclk);
         if (d_ack || d_err) n_ack++;
      end
      chk("t6_no_ack", n_ack, 0);
      d_req = 1; d_write = 1; d_fn3 = 3'b000; d_addr = 32'hB000_0003;
      d_wdata = 32'h0000_00A5;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge hclk);
         if (d_ack) begin done = 1; d_req = 0; end
      end
      chk("t6_new_ack", done, 1);
      d_req = 0;
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Single-master AHB-Lite front end for the RISC-V core. It sequences instruction fetch and load/store requests onto one shared AHB-Lite master port.
- Arbitrates between the two requesters, drives address and data phases, and handles hready wait states and the two-cycle hresp error response.
- Returns read data with a per-requester ack or error pulse. Sits between the core pipeline and the AHB decoder/slave mux.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_DATA_RUN, 4, maximum consecutive data grants while a fetch is pending; range 1..15.

Ports:
- hclk  in  1  bus clock.
- hreset  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request; held until f_ack or f_err.
- f_addr  in  ADDR_W  fetch address (pc).
- f_ack  out  1  one-cycle pulse: fetch done, rdata valid.
- f_err  out  1  one-cycle pulse: fetch failed.
- d_req  in  1  load/store request; held until d_ack or d_err.
- d_write  in  1  1 = store, 0 = load.
- d_fn3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- d_addr  in  ADDR_W  effective address (alu_out).
- d_wdata  in  DATA_W  store data (rs2_data).
- d_ack  out  1  one-cycle pulse: data access done.
- d_err  out  1  one-cycle pulse: bus error or misaligned access.
- d_misalign  out  1  qualifies d_err; 1 = misaligned, no bus transfer issued.
- rdata  out  DATA_W  registered hrdata of the last completed read.
- is_signed  out  1  1 for fn3 000/001/010 of the granted data access.
- muxsel  out  1  1 = fetch owns the current or last completed transfer.
- busy  out  1  state != IDLE.
- htrans  out  2  00 IDLE or 10 NONSEQ only.
- haddr  out  ADDR_W  address-phase address.
- hwrite  out  1  write flag.
- hsize  out  3  000/001/010.
- hprot  out  4  0000 fetch, 0001 data.
- hwdata  out  DATA_W  write data, data phase.
- hrdata  in  DATA_W  read data.
- hready  in  1  transfer ready.
- hresp  in  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset values: all outputs 0 (htrans=00, hsize=000, rdata=0); state=IDLE; run counter=0.
- Reset asserted mid-transfer abandons the transfer. No ack or err is issued for it.
- All outputs are registered. There is one outstanding transfer at most, with no address/data overlap.

State machine (IDLE, ADDR, DATA, ERR, RESP):
- IDLE: if any request is present, latch the winner's attributes and go to ADDR (htrans=10 in the next cycle). No requests: stay in IDLE, htrans=00.
- Arbitration priority: d_req wins over f_req, except that fetch wins when f_req=1 and the run counter equals MAX_DATA_RUN.
- Run counter: increments on each data grant while f_req=1; clears on any fetch grant or when f_req=0.
- Misaligned data (H with addr[0]=1; W with addr[1:0]!=0): no bus transfer. Go directly to RESP with d_err=1 and d_misalign=1.
- ADDR: drive haddr, hwrite, hsize, hprot, htrans=10.
  - hready=0: hold all of them.
  - hready=1: go to DATA; htrans=00; hwdata=d_wdata for a store.
- DATA: hold hwdata.
  - hready=1 and hresp=0: capture hrdata into rdata for a read; go to RESP with ack.
  - hresp=1 (with either hready value): go to ERR.
- ERR: wait for hready=1, then go to RESP with err. hwdata is held.
- RESP: exactly one cycle. The granted requester's ack or err is 1. No arbitration happens in this cycle, so a request still held here is not regranted. Then go to IDLE.
- Zero-wait latency: request first seen in IDLE at cycle 0 → address phase in cycle 1 → data phase in cycle 2 → ack/rdata in cycle 3 → IDLE in cycle 4. Peak rate is one transfer per 4 cycles.
- hsize:
  - fetch: always 010.
  - data: 000 for fn3 000/100; 001 for 001/101; 010 for 010.
  - any other fn3: 010, treated as W.
- muxsel: updates at grant and is held through RESP.
- Requests that change while not granted are ignored. Attributes are latched only at grant.

Test Plan:
- Reset with f_req=1, f_addr=0xA000_0000, zero-wait slave → htrans=10 with haddr=0xA000_0000 and hprot=0000 at cycle 1; f_ack and muxsel=1 at cycle 3; rdata=hrdata.
- d_req store: fn3=001, addr=0xB000_0002, wdata=0x1234_5678; hready low for 2 cycles in ADDR → haddr held for 3 cycles; hsize=001; hwdata=0x1234_5678 in data phase; d_ack once.
- f_req and d_req held continuously, MAX_DATA_RUN=4 → grant order D,D,D,D,F,D,D,D,D,F.
- Load fn3=010 at addr 0xB000_0001 → no htrans=10 issued; d_err=1 and d_misalign=1 one cycle after grant.
- Slave gives hresp=1 with hready=0, then hresp=1 with hready=1 in data phase → f_err pulse; rdata unchanged; f_ack never asserted.
- hreset asserted in DATA state → next cycle all outputs are 0 and state is IDLE; no ack for the aborted transfer; a new request completes normally.
